// File: rtl/ccff_chain_loader_pkg.sv
// ----------------------------------------------------------------------------
// ccff_loader_pkg
//   Shared types and helpers for the configuration-chain loader.
//   - ccff_state_e : loader FSM state encoding
//   - CCFF_WORDS   : bitstream words needed to fill a chain (ceil divide)
// ----------------------------------------------------------------------------
package ccff_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_WORD = 2'd1,
      ST_SHIFT     = 2'd2,
      ST_DONE      = 2'd3
   } ccff_state_e;

   function automatic int unsigned CCFF_WORDS(input int unsigned chain_len,
                                              input int unsigned word_w);
      return (chain_len + word_w - 1) / word_w;
   endfunction

endpackage

// File: rtl/ccff_chain_loader_rb_packer.sv
// ----------------------------------------------------------------------------
// ccff_rb_packer
//   Serial-to-word packer for configuration-chain readback. Bits arrive
//   LSB-first, one per i_sample cycle. A full word, or a partial word marked
//   with i_flush, is presented on o_data with a one-cycle o_valid pulse;
//   unfilled high bits of a flushed word are zero.
//
// Ports:
//   i_clk    in   clock, rising edge
//   i_rst_n  in   asynchronous active-low reset
//   i_clear  in   drop any partially packed word (start of a new load)
//   i_sample in   i_bit is valid this cycle
//   i_bit    in   serial readback bit
//   i_flush  in   this sample is the final one; emit even if word not full
//   o_data   out  packed word (WORD_W bits), held until the next word
//   o_valid  out  one-cycle pulse per emitted word
// ----------------------------------------------------------------------------
module ccff_rb_packer
   import ccff_loader_pkg::*;
#(
   parameter int unsigned WORD_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clear,
   input  logic              i_sample,
   input  logic              i_bit,
   input  logic              i_flush,
   output logic [WORD_W-1:0] o_data,
   output logic              o_valid
);

   localparam int unsigned     WB_W      = $clog2(WORD_W);
   localparam logic [WB_W-1:0] LAST_WBIT = WB_W'(WORD_W - 1);

   logic [WORD_W-1:0] r_acc;
   logic [WB_W-1:0]   r_cnt;
   logic [WORD_W-1:0] r_data;
   logic              r_valid;
   logic [WORD_W-1:0] w_acc_next;

   // r_acc is always zero above r_cnt, so a flushed word is zero-padded
   always_comb begin
      w_acc_next        = r_acc;
      w_acc_next[r_cnt] = i_bit;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc   <= '0;
         r_cnt   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (i_clear) begin
            r_acc <= '0;
            r_cnt <= '0;
         end else if (i_sample) begin
            if ((r_cnt == LAST_WBIT) || i_flush) begin
               r_data  <= w_acc_next;
               r_valid <= 1'b1;
               r_acc   <= '0;
               r_cnt   <= '0;
            end else begin
               r_acc <= w_acc_next;
               r_cnt <= r_cnt + WB_W'(1);
            end
         end
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;

endmodule

// File: rtl/ccff_chain_loader.sv
// ----------------------------------------------------------------------------
// ccff_chain_loader
//   Drives the fabric configuration chain (ccff_head -> ... -> ccff_tail) from
//   a valid/ready bitstream source. Serializes exactly CHAIN_LEN bits, LSB of
//   each word first, gates fabric shifting with ccff_shift_en and holds the
//   IO tiles isolated until a load completes.
//
// Build option:
//   CCFF_READBACK_EN  when defined, the previous chain contents coming out of
//                     ccff_tail are packed into words on rb_data/rb_valid.
//                     When undefined, rb_* ports and the packer are absent.
//
// Ports:
//   prog_clk       in   programming clock, rising edge
//   prog_reset_n   in   asynchronous active-low reset
//   start          in   begin a load (honoured only when idle)
//   abort          in   cancel a load in progress
//   bs_data        in   bitstream word, bit 0 shifted first
//   bs_valid       in   bs_data valid
//   bs_ready       out  loader accepts a word this cycle
//   ccff_head      out  serial bit into the chain head
//   ccff_shift_en  out  fabric clock-gate enable; chain shifts when 1
//   ccff_tail      in   serial bit from the chain tail (readback only)
//   IO_ISOL_N      out  IO isolation, 0 = isolated
//   busy           out  load in progress
//   done           out  one-cycle pulse on successful completion
//   rb_data        out  readback word (CCFF_READBACK_EN)
//   rb_valid       out  readback word valid pulse (CCFF_READBACK_EN)
// ----------------------------------------------------------------------------
module ccff_chain_loader
   import ccff_loader_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = 20,
   parameter int unsigned WORD_W    = 32
) (
   input  logic              prog_clk,
   input  logic              prog_reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] bs_data,
   input  logic              bs_valid,
   output logic              bs_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              IO_ISOL_N,
   output logic              busy,
   output logic              done
`ifdef CCFF_READBACK_EN
   ,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid
`endif
);

   localparam int unsigned     BC_W      = $clog2(CHAIN_LEN + 1);
   localparam int unsigned     WB_W      = $clog2(WORD_W);
   localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(CHAIN_LEN - 1);
   localparam logic [WB_W-1:0] LAST_WBIT = WB_W'(WORD_W - 1);

   ccff_state_e       r_state;
   logic [WORD_W-1:0] r_sreg;
   logic [BC_W-1:0]   r_bit_cnt;
   logic [WB_W-1:0]   r_wbit_cnt;
   logic              r_bs_ready;
   logic              r_head;
   logic              r_shift_en;
   logic              r_isol_n;
   logic              r_busy;
   logic              r_done;

   logic              w_abort;
   logic              w_accept;
   logic              w_issue;
   logic              w_issue_bit;
   logic              w_last_chain;
   logic              w_last_word;
   logic [WORD_W-1:0] w_sreg_next;

   // The accepting edge already drives bit 0 onto ccff_head, so the first
   // shift cycle directly follows the handshake; later bits come from r_sreg.
   always_comb begin
      w_abort      = abort && (r_state != ST_IDLE);
      w_accept     = (r_state == ST_WAIT_WORD) && r_bs_ready && bs_valid && !abort;
      w_issue      = w_accept || ((r_state == ST_SHIFT) && !abort);
      w_issue_bit  = w_accept ? bs_data[0] : r_sreg[0];
      w_sreg_next  = w_accept ? (bs_data >> 1) : (r_sreg >> 1);
      w_last_chain = (r_bit_cnt == LAST_BIT);
      w_last_word  = (r_wbit_cnt == LAST_WBIT);
   end

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         r_state    <= ST_IDLE;
         r_sreg     <= '0;
         r_bit_cnt  <= '0;
         r_wbit_cnt <= '0;
         r_bs_ready <= 1'b0;
         r_head     <= 1'b0;
         r_shift_en <= 1'b0;
         r_isol_n   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_abort) begin
            // IO stays isolated: the chain holds a partial configuration
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_bs_ready <= 1'b0;
            r_shift_en <= 1'b0;
            r_head     <= 1'b0;
         end else if (w_issue) begin
            r_head     <= w_issue_bit;
            r_shift_en <= 1'b1;
            r_bs_ready <= 1'b0;
            r_sreg     <= w_sreg_next;
            r_bit_cnt  <= r_bit_cnt + BC_W'(1);
            if (w_last_chain || w_last_word) begin
               r_wbit_cnt <= '0;
            end else begin
               r_wbit_cnt <= r_wbit_cnt + WB_W'(1);
            end
            // Chain end wins over word end: spare high bits are dropped
            if (w_last_chain) begin
               r_state <= ST_DONE;
            end else if (w_last_word) begin
               r_state <= ST_WAIT_WORD;
            end else begin
               r_state <= ST_SHIFT;
            end
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_shift_en <= 1'b0;
                  r_head     <= 1'b0;
                  if (start) begin
                     r_busy     <= 1'b1;
                     r_isol_n   <= 1'b0;
                     r_bit_cnt  <= '0;
                     r_wbit_cnt <= '0;
                     r_bs_ready <= 1'b1;
                     r_state    <= ST_WAIT_WORD;
                  end
               end
               ST_WAIT_WORD: begin
                  // Entered from a word's last bit with ready low; raising it
                  // here gives the single bubble cycle between words.
                  r_shift_en <= 1'b0;
                  r_head     <= 1'b0;
                  r_bs_ready <= 1'b1;
               end
               ST_DONE: begin
                  r_shift_en <= 1'b0;
                  r_head     <= 1'b0;
                  r_done     <= 1'b1;
                  r_isol_n   <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= ST_IDLE;
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign bs_ready      = r_bs_ready;
   assign ccff_head     = r_head;
   assign ccff_shift_en = r_shift_en;
   assign IO_ISOL_N     = r_isol_n;
   assign busy          = r_busy;
   assign done          = r_done;

`ifdef CCFF_READBACK_EN
   logic w_rb_clear;
   logic w_rb_flush;

   // The DONE cycle is the last shift cycle, so its sample closes the word
   assign w_rb_clear = (r_state == ST_IDLE) && start;
   assign w_rb_flush = (r_state == ST_DONE) && !abort;

   ccff_rb_packer #(
      .WORD_W (WORD_W)
   ) u_rb_packer (
      .i_clk    (prog_clk),
      .i_rst_n  (prog_reset_n),
      .i_clear  (w_rb_clear),
      .i_sample (r_shift_en),
      .i_bit    (ccff_tail),
      .i_flush  (w_rb_flush),
      .o_data   (rb_data),
      .o_valid  (rb_valid)
   );
`else
   logic w_unused_tail;
   assign w_unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;
   import ccff_loader_pkg::*;

   localparam int unsigned CL = 20;
   localparam int unsigned WW = 8;

   logic          prog_clk = 1'b0;
   logic          prog_reset_n;
   logic          start;
   logic          abort;
   logic [WW-1:0] bs_data;
   logic          bs_valid;
   logic          bs_ready;
   logic          ccff_head;
   logic          ccff_shift_en;
   logic          ccff_tail;
   logic          IO_ISOL_N;
   logic          busy;
   logic          done;
`ifdef CCFF_READBACK_EN
   logic [WW-1:0] rb_data;
   logic          rb_valid;
`endif

   ccff_chain_loader #(
      .CHAIN_LEN (CL),
      .WORD_W    (WW)
   ) dut (
      .prog_clk      (prog_clk),
      .prog_reset_n  (prog_reset_n),
      .start         (start),
      .abort         (abort),
      .bs_data       (bs_data),
      .bs_valid      (bs_valid),
      .bs_ready      (bs_ready),
      .ccff_head     (ccff_head),
      .ccff_shift_en (ccff_shift_en),
      .ccff_tail     (ccff_tail),
      .IO_ISOL_N     (IO_ISOL_N),
      .busy          (busy),
      .done          (done)
`ifdef CCFF_READBACK_EN
      ,
      .rb_data       (rb_data),
      .rb_valid      (rb_valid)
`endif
   );

   always #5 prog_clk = ~prog_clk;

   // Fabric chain model: shifts only on gated edges
   logic [CL-1:0] chain = '0;
   always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head};
   assign ccff_tail = chain[CL-1];

   int n_cmp = 0;
   int n_err = 0;
   logic          q_head[$];
   int            q_done[$];
   logic [WW-1:0] q_rb[$];
   int n_hs, n_shift, first_cyc, last_cyc;
   int cyc = 0;
   bit rb_check = 1'b0;
   logic          mon_bit;
   logic [WW-1:0] mon_word;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops scoreboard entries whenever the DUT presents an output
   always @(negedge prog_clk) begin
      cyc++;
      if (prog_reset_n) begin
         if (bs_valid && bs_ready) n_hs++;
         if (ccff_shift_en) begin
            n_shift++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            if (q_head.size() == 0) begin
               chk("shift_en_unexpected", ccff_shift_en, 0);
            end else begin
               mon_bit = q_head.pop_front();
               chk("ccff_head", ccff_head, mon_bit);
               chk("isol_while_shifting", IO_ISOL_N, 0);
            end
         end
         if (done) begin
            if (q_done.size() == 0) begin
               chk("done_unexpected", done, 0);
            end else begin
               void'(q_done.pop_front());
               chk("isol_at_done", IO_ISOL_N, 1);
               chk("busy_at_done", busy, 0);
            end
         end
`ifdef CCFF_READBACK_EN
         if (rb_check && rb_valid) begin
            if (q_rb.size() == 0) begin
               chk("rb_valid_unexpected", rb_valid, 0);
            end else begin
               mon_word = q_rb.pop_front();
               chk("rb_data", rb_data, mon_word);
            end
         end
`endif
      end
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_bs_ready"}, bs_ready, 0);
      chk({tag, "_ccff_head"}, ccff_head, 0);
      chk({tag, "_shift_en"}, ccff_shift_en, 0);
      chk({tag, "_io_isol_n"}, IO_ISOL_N, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
`ifdef CCFF_READBACK_EN
      chk({tag, "_rb_data"}, rb_data, 0);
      chk({tag, "_rb_valid"}, rb_valid, 0);
`endif
   endtask

   task automatic push_bits(input logic [23:0] v, input int n);
      for (int i = 0; i < n; i++) q_head.push_back(v[i]);
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge prog_clk);
         if (bs_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("ready_timeout", bs_ready, 1);
   endtask

   task automatic wait_done();
      bit ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge prog_clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("done_timeout", done, 1);
   endtask

   // Called and returns at posedge+1
   task automatic do_start();
      @(posedge prog_clk); #1;
      start = 1'b1;
      chk("ready_idle", bs_ready, 0);
      @(posedge prog_clk); #1;
      start = 1'b0;
      chk("ready_after_start", bs_ready, 1);
      chk("busy_after_start", busy, 1);
      chk("isol_after_start", IO_ISOL_N, 0);
   endtask

   task automatic send_word(input logic [WW-1:0] w, input int gap);
      bit ok;
      bs_data = w;
      if (gap > 0) begin
         wait_ready(ok);
         for (int i = 0; i < gap; i++) begin
            @(negedge prog_clk);
            chk("gap_shift_en", ccff_shift_en, 0);
         end
         @(posedge prog_clk); #1;
      end
      bs_valid = 1'b1;
      wait_ready(ok);
      @(posedge prog_clk); #1;
      bs_valid = 1'b0;
      chk("hs_to_shift", ccff_shift_en, 1);
   endtask

   task automatic do_load(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                          input logic [WW-1:0] w2, input int gap, input bit poke);
      logic [23:0] v;
      v = {w2, w1, w0};
      n_hs = 0;
      n_shift = 0;
      first_cyc = -1;
      last_cyc = -1;
      push_bits(v, CL);
      q_done.push_back(1);
      do_start();
      send_word(w0, gap);
      send_word(w1, gap);
      if (poke) begin
         start = 1'b1;
         @(posedge prog_clk); #1;
         start = 1'b0;
      end
      send_word(w2, gap);
      wait_done();
      @(posedge prog_clk); #1;
      chk("done_one_cycle", done, 0);
      chk("isol_released", IO_ISOL_N, 1);
      chk("busy_after_done", busy, 0);
      chk("bits_pending", q_head.size(), 0);
      chk("done_pending", q_done.size(), 0);
      chk("shift_cycles", n_shift, CL);
      chk("words_taken", n_hs, CCFF_WORDS(CL, WW));
      if (gap == 0) chk("shift_span", last_cyc - first_cyc + 1, CL + 2);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit ok;
      prog_reset_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      bs_valid = 1'b0;
      bs_data = '0;
      repeat (3) @(posedge prog_clk);
      #1;
      chk_reset_vals("reset");
      prog_reset_n = 1'b1;
      repeat (2) @(posedge prog_clk);
      #1;
      chk("ready_idle_after_reset", bs_ready, 0);

      // Basic load: expected head stream 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1
      do_load(8'hA5, 8'h3C, 8'h0F, 0, 1'b0);

      // Stalls between words
      do_load(8'hA5, 8'h3C, 8'h0F, 5, 1'b0);

      // Abort while waiting for the second word, with that word offered
      push_bits(24'h0000A5, 8);
      do_start();
      send_word(8'hA5, 0);
      wait_ready(ok);
      @(posedge prog_clk); #1;
      bs_data = 8'h3C;
      bs_valid = 1'b1;
      abort = 1'b1;
      @(posedge prog_clk); #1;
      abort = 1'b0;
      bs_valid = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_ready", bs_ready, 0);
      chk("abort_shift_en", ccff_shift_en, 0);
      chk("abort_isol", IO_ISOL_N, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge prog_clk);
         chk("abort_no_done", done, 0);
      end
      chk("abort_bits_pending", q_head.size(), 0);
      do_load(8'h5A, 8'hC3, 8'hF0, 0, 1'b0);

      // Reset two shift cycles into the second word
      push_bits({8'h00, 8'h3C, 8'hA5}, 10);
      do_start();
      send_word(8'hA5, 0);
      send_word(8'h3C, 0);
      repeat (2) @(posedge prog_clk);
      #1;
      prog_reset_n = 1'b0;
      #1;
      chk_reset_vals("midreset");
      @(posedge prog_clk); #1;
      prog_reset_n = 1'b1;
      chk("midreset_bits_pending", q_head.size(), 0);
      do_load(8'hA5, 8'h3C, 8'h0F, 0, 1'b0);

      // Start pulsed during SHIFT is ignored
      do_load(8'h81, 8'h7E, 8'h03, 0, 1'b1);

`ifdef CCFF_READBACK_EN
      do_load(8'hA5, 8'h3C, 8'h0F, 0, 1'b0);
      q_rb.push_back(8'hA5);
      q_rb.push_back(8'h3C);
      q_rb.push_back(8'h0F);
      rb_check = 1'b1;
      do_load(8'h00, 8'h00, 8'h00, 0, 1'b0);
      rb_check = 1'b0;
      chk("rb_words_pending", q_rb.size(), 0);
`endif

      repeat (3) @(posedge prog_clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Configuration-chain loader that drives the fabric's `ccff_head` / `ccff_tail` shift chain from the programming side. It accepts bitstream words over a valid/ready handshake and serializes exactly `CHAIN_LEN` bits onto `ccff_head`. It gates fabric shifting with a clock-enable and holds the IO tiles isolated (`IO_ISOL_N` low) until programming completes. It sits between the SoC bitstream source and the head of the grid's configuration chain, with the chain's final `ccff_tail` returned to it.

## Interface
Parameters:
- `CHAIN_LEN`, default 20, total configuration flip-flops in the chain, ≥1.
- `WORD_W`, default 32, bitstream word width, ≥2.

Ports:
- `prog_clk`  in  1  programming clock; all logic on its rising edge.
- `prog_reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load; honoured only in IDLE.
- `abort`  in  1  cancels a load in progress.
- `bs_data`  in  `WORD_W`  bitstream word; bit 0 is shifted first.
- `bs_valid`  in  1  `bs_data` valid.
- `bs_ready`  out  1  loader can accept a word.
- `ccff_head`  out  1  serial bit into the chain head.
- `ccff_shift_en`  out  1  fabric `prog_clk` gate enable; chain shifts only on edges where this is 1.
- `ccff_tail`  in  1  serial bit from the chain tail.
- `IO_ISOL_N`  out  1  IO isolation, active-low; 0 means isolated.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse on successful completion.
- `rb_data`  out  `WORD_W`  readback word; present only with `CCFF_READBACK_EN`.
- `rb_valid`  out  1  readback word valid pulse; present only with `CCFF_READBACK_EN`.

## Operation
- States: IDLE, WAIT_WORD, SHIFT, DONE.
- **IDLE:** `bs_ready`=0. On `start`: assert `busy`, drive `IO_ISOL_N`=0, clear the counters, go to WAIT_WORD.
- **WAIT_WORD:** `bs_ready`=1. A handshake (`bs_valid` && `bs_ready`) loads the shift register and goes to SHIFT.
- **SHIFT:** once per cycle, register `ccff_head` = sreg[0] and `ccff_shift_en` = 1, then shift sreg right and increment `bit_cnt` and `wbit_cnt`.
  - Last chain bit issued (`bit_cnt` = `CHAIN_LEN`-1) → DONE. Any unused high bits of the final word are discarded.
  - Otherwise, when `wbit_cnt` = `WORD_W`-1 → WAIT_WORD.
- **DONE:** pulse `done` for one cycle, set `IO_ISOL_N`=1, deassert `busy`, go to IDLE.
- Words consumed per load = ceil(`CHAIN_LEN`/`WORD_W`).
- Counter widths: `bit_cnt` is $clog2(`CHAIN_LEN`+1) bits; `wbit_cnt` is $clog2(`WORD_W`) bits. Neither wraps within a load.
- `abort` in any non-IDLE state → IDLE on the next edge.
  - `busy`=0, no `done`, `IO_ISOL_N` stays 0.
  - `abort` takes priority over a same-cycle handshake; that word is not consumed.
- `start` outside IDLE is ignored. `start` and `bs_valid` in the same IDLE cycle: the word is not accepted.
- Reset asserted mid-load abandons the load. Chain contents are then undefined and the IO stays isolated.

## Timing
- Reset values: `bs_ready`=0, `ccff_head`=0, `ccff_shift_en`=0, `IO_ISOL_N`=0, `busy`=0, `done`=0, `rb_data`=0, `rb_valid`=0.
- `start` at edge t → `bs_ready`=1 in cycle t+1.
- Handshake at edge t → `ccff_shift_en`=1 for cycles t+1 through t+k, with `ccff_head` carrying bit j in cycle t+1+j (k = bits taken from that word).
- Gaps in `bs_valid` produce cycles with `ccff_shift_en`=0; the chain holds during them.
- Back-to-back words: there is one WAIT_WORD bubble cycle between words.
- `done` and `IO_ISOL_N` rising occur in the cycle after the last shift cycle.

## Configuration
- `CCFF_READBACK_EN` defined:
  - On every edge with `ccff_shift_en`=1, sample `ccff_tail` and pack LSB-first into `rb_data`.
  - `rb_valid` pulses for one cycle per full word. The final partial word is zero-padded and emitted no later than the `done` cycle.
  - Words emitted = ceil(`CHAIN_LEN`/`WORD_W`).
  - This returns the previous chain contents in the order they were loaded.
- `CCFF_READBACK_EN` undefined: `rb_data` and `rb_valid` ports and the packer logic are absent. `ccff_tail` is unused.

## Structure
- `ccff_loader_pkg`: state enum, and a `CCFF_WORDS(CHAIN_LEN, WORD_W)` ceil-divide function.
- Sub-module `ccff_rb_packer` (serial-to-word packer with flush), instantiated only under `CCFF_READBACK_EN`.

## Test plan
All scenarios use `CHAIN_LEN`=20, `WORD_W`=8.
- **Basic load:** `start`, then words 0xA5, 0x3C, 0x0F with `bs_valid` held high → `ccff_head` over the shift cycles = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1; exactly 20 `ccff_shift_en` cycles; `done` one cycle; `IO_ISOL_N` goes 0→1.
- **Stalls:** same words with 5-cycle `bs_valid` gaps → identical bit sequence; `ccff_shift_en`=0 throughout the gaps.
- **Abort:** `abort` after the first word → IDLE, `busy`=0, no `done`, `IO_ISOL_N`=0; a subsequent full load completes normally.
- **Mid-shift reset:** `prog_reset_n` low during the second word → all outputs at their reset values; the loader restarts cleanly on the next `start`.
- **Ignored start:** `start` pulsed during SHIFT → no effect; exactly 3 words consumed.
- **Readback (`CCFF_READBACK_EN`):** load 0xA5, 0x3C, 0x0F into a 20-FF chain model, then load 0x00 ×3 → `rb_data` = 0xA5, 0x3C, 0x0F, each with one `rb_valid` pulse.
